// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sequencer sharing a byte-wide memory between fetch and load/store.
// Optional feature macro MEM_ARB_MISALIGN_TRAP_EN traps misaligned requests without touching memory.
module mem_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [31:0]       if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [1:0]        ls_size,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [31:0]       ls_wdata,
  output logic              ls_done,
  output logic [31:0]       ls_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              busy,
  output logic              if_err,
  output logic              ls_err
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  function automatic logic [2:0] size_to_len(input logic [1:0] size);
    logic [2:0] len;
    case (size)
      2'b00:   len = 3'd1;
      2'b01:   len = 3'd2;
      default: len = 3'd4;
    endcase
    return len;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lsb);
    logic mis;
    case (size)
      2'b00:   mis = 1'b0;
      2'b01:   mis = lsb[0];
      default: mis = (lsb != 2'b00);
    endcase
    return mis;
  endfunction

  state_t              state_r;
  logic                owner_r;   // 1 = load/store owns the transaction
  logic                last_r;    // 1 = load/store was granted last
  logic [ADDR_W-1:0]   base_r;
  logic                we_r;
  logic [2:0]          len_r;
  logic [1:0]          cnt_r;
  logic [31:0]         wdata_r;
  logic [31:0]         res_r;

  logic                gnt_valid_s;
  logic                gnt_ls_s;
  logic [ADDR_W-1:0]   gnt_addr_s;
  logic                gnt_we_s;
  logic [1:0]          gnt_size_s;
  logic [31:0]         gnt_wdata_s;
  logic                gnt_trap_s;
  logic                last_byte_s;
  logic [1:0]          cnt_nxt_s;
  logic [31:0]         res_s;

  // Round-robin grant and selection of the winning requester's fields
  always_comb begin
    gnt_valid_s = 1'b0;
    gnt_ls_s    = 1'b0;
    if (if_req && ls_req) begin
      gnt_valid_s = 1'b1;
      gnt_ls_s    = ~last_r;
    end else if (ls_req) begin
      gnt_valid_s = 1'b1;
      gnt_ls_s    = 1'b1;
    end else if (if_req) begin
      gnt_valid_s = 1'b1;
      gnt_ls_s    = 1'b0;
    end else begin
      gnt_valid_s = 1'b0;
      gnt_ls_s    = 1'b0;
    end
    gnt_addr_s  = gnt_ls_s ? ls_addr : if_addr;
    gnt_we_s    = gnt_ls_s & ls_we;
    gnt_size_s  = gnt_ls_s ? ls_size : 2'b10;
    gnt_wdata_s = gnt_ls_s ? ls_wdata : 32'h0000_0000;
`ifdef MEM_ARB_MISALIGN_TRAP_EN
    gnt_trap_s  = is_misaligned(gnt_size_s, gnt_addr_s[1:0]);
`else
    gnt_trap_s  = 1'b0;
`endif
  end

  // Byte-lane capture and sequencing helpers for the ACCESS state
  always_comb begin
    res_s       = res_r;
    cnt_nxt_s   = cnt_r + 2'd1;
    last_byte_s = ({1'b0, cnt_r} == (len_r - 3'd1));
    if (!we_r) begin
      res_s[{cnt_r, 3'b000} +: 8] = mem_rdata;
    end else begin
      res_s = res_r;
    end
  end

  // Main sequencer: grant, byte issue, done pulse; all outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= S_IDLE;
      owner_r   <= 1'b0;
      last_r    <= 1'b1;
      base_r    <= '0;
      we_r      <= 1'b0;
      len_r     <= 3'd0;
      cnt_r     <= 2'd0;
      wdata_r   <= 32'h0000_0000;
      res_r     <= 32'h0000_0000;
      if_done   <= 1'b0;
      if_rdata  <= 32'h0000_0000;
      ls_done   <= 1'b0;
      ls_rdata  <= 32'h0000_0000;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= 8'h00;
      busy      <= 1'b0;
      if_err    <= 1'b0;
      ls_err    <= 1'b0;
    end else begin
      if_done <= 1'b0;
      ls_done <= 1'b0;
      if_err  <= 1'b0;
      ls_err  <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (gnt_valid_s) begin
            owner_r <= gnt_ls_s;
            base_r  <= gnt_addr_s;
            we_r    <= gnt_we_s;
            len_r   <= size_to_len(gnt_size_s);
            wdata_r <= gnt_wdata_s;
            res_r   <= 32'h0000_0000;
            cnt_r   <= 2'd0;
            busy    <= 1'b1;
            if (gnt_trap_s) begin
              // Trapped request: no memory traffic, zero data, err alongside done
              state_r <= S_DONE;
              last_r  <= gnt_ls_s;
              if (gnt_ls_s) begin
                ls_done  <= 1'b1;
                ls_err   <= 1'b1;
                ls_rdata <= 32'h0000_0000;
              end else begin
                if_done  <= 1'b1;
                if_err   <= 1'b1;
                if_rdata <= 32'h0000_0000;
              end
            end else begin
              state_r   <= S_ACCESS;
              mem_addr  <= gnt_addr_s;
              mem_we    <= gnt_we_s;
              mem_wdata <= gnt_wdata_s[7:0];
            end
          end else begin
            state_r <= S_IDLE;
            busy    <= 1'b0;
          end
        end
        S_ACCESS: begin
          res_r <= res_s;
          if (last_byte_s) begin
            state_r   <= S_DONE;
            last_r    <= owner_r;
            cnt_r     <= 2'd0;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= 8'h00;
            if (owner_r) begin
              ls_done  <= 1'b1;
              ls_rdata <= res_s;
            end else begin
              if_done  <= 1'b1;
              if_rdata <= res_s;
            end
          end else begin
            cnt_r     <= cnt_nxt_s;
            mem_addr  <= base_r + {{(ADDR_W-2){1'b0}}, cnt_nxt_s};
            mem_wdata <= wdata_r[{cnt_nxt_s, 3'b000} +: 8];
          end
        end
        S_DONE: begin
          state_r <= S_IDLE;
          busy    <= 1'b0;
        end
        default: begin
          state_r   <= S_IDLE;
          busy      <= 1'b0;
          mem_addr  <= '0;
          mem_we    <= 1'b0;
          mem_wdata <= 8'h00;
        end
      endcase
    end
  end

endmodule
